// File: rtl/ps2_note_mapper_pkg.sv
// Shared constants, types and the clock-dependent note table for the PS/2 note mapper.
// Scan codes are PS/2 set 2; notes are indexed 0 (C4) .. 12 (C5).
package ps2_note_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_OCT_DN = 8'h1A;
  localparam logic [7:0] SC_OCT_UP = 8'h22;

  localparam logic [7:0] SC_C4  = 8'h1C;
  localparam logic [7:0] SC_CS4 = 8'h1D;
  localparam logic [7:0] SC_D4  = 8'h1B;
  localparam logic [7:0] SC_DS4 = 8'h24;
  localparam logic [7:0] SC_E4  = 8'h23;
  localparam logic [7:0] SC_F4  = 8'h2B;
  localparam logic [7:0] SC_FS4 = 8'h2C;
  localparam logic [7:0] SC_G4  = 8'h34;
  localparam logic [7:0] SC_GS4 = 8'h35;
  localparam logic [7:0] SC_A4  = 8'h33;
  localparam logic [7:0] SC_AS4 = 8'h3C;
  localparam logic [7:0] SC_B4  = 8'h3B;
  localparam logic [7:0] SC_C5  = 8'h42;

  localparam int         HP_W      = 26;
  localparam int         NUM_NOTES = 13;
  localparam logic [3:0] NOTE_NONE = 4'hF;

  localparam logic signed [2:0] OCT_MIN = -3'sd2;
  localparam logic signed [2:0] OCT_MAX =  3'sd2;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_BREAK,
    DEC_EXT,
    DEC_EXT_BREAK
  } dec_state_t;

  function automatic logic [3:0] note_of(input logic [7:0] code);
    logic [3:0] n;
    case (code)
      SC_C4:   n = 4'd0;
      SC_CS4:  n = 4'd1;
      SC_D4:   n = 4'd2;
      SC_DS4:  n = 4'd3;
      SC_E4:   n = 4'd4;
      SC_F4:   n = 4'd5;
      SC_FS4:  n = 4'd6;
      SC_G4:   n = 4'd7;
      SC_GS4:  n = 4'd8;
      SC_A4:   n = 4'd9;
      SC_AS4:  n = 4'd10;
      SC_B4:   n = 4'd11;
      SC_C5:   n = 4'd12;
      default: n = NOTE_NONE;
    endcase
    return n;
  endfunction

  // Frequencies in millihertz keep the table integer-only; result is round(clk/(2f)).
  function automatic longint note_base(input longint clk_hz, input int idx);
    longint f_mhz;
    case (idx)
      0:       f_mhz = 64'd261626;
      1:       f_mhz = 64'd277183;
      2:       f_mhz = 64'd293665;
      3:       f_mhz = 64'd311127;
      4:       f_mhz = 64'd329628;
      5:       f_mhz = 64'd349228;
      6:       f_mhz = 64'd369994;
      7:       f_mhz = 64'd391995;
      8:       f_mhz = 64'd415305;
      9:       f_mhz = 64'd440000;
      10:      f_mhz = 64'd466164;
      11:      f_mhz = 64'd493883;
      12:      f_mhz = 64'd523251;
      default: f_mhz = 64'd440000;
    endcase
    return (clk_hz * 64'd1000 + f_mhz) / (64'd2 * f_mhz);
  endfunction

endpackage

// File: rtl/ps2_note_mapper_if.sv
// Byte-stream input and note-selection output bundle of the PS/2 note mapper.
// The slave side is the mapper; the master side is the surrounding system.
interface ps2_note_mapper_if;
  import ps2_note_pkg::*;

  logic [7:0]        scan_code;
  logic              scan_valid;
  logic [HP_W-1:0]   half_period;
  logic              note_on;
  logic signed [2:0] octave;

  modport master (
    output scan_code, scan_valid,
    input  half_period, note_on, octave
  );

  modport slave (
    input  scan_code, scan_valid,
    output half_period, note_on, octave
  );
endinterface

// File: rtl/ps2_note_mapper_code_decoder.sv
// PS/2 set-2 prefix decoder: turns F0/E0-prefixed byte sequences into make/break strobes.
// Strobes are combinational from the registered state so events land with 1-cycle output latency.
module ps2_code_decoder
  import ps2_note_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       make_evt,
  output logic       break_evt,
  output logic [7:0] code
);

  dec_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DEC_IDLE;
    end else if (scan_valid) begin
      case (state)
        DEC_IDLE: begin
          if (scan_code == SC_BREAK)    state <= DEC_BREAK;
          else if (scan_code == SC_EXT) state <= DEC_EXT;
          else                          state <= DEC_IDLE;
        end
        DEC_BREAK:     state <= DEC_IDLE;
        DEC_EXT: begin
          if (scan_code == SC_BREAK) state <= DEC_EXT_BREAK;
          else                       state <= DEC_IDLE;
        end
        DEC_EXT_BREAK: state <= DEC_IDLE;
        default:       state <= DEC_IDLE;
      endcase
    end
  end

  always_comb begin
    make_evt  = 1'b0;
    break_evt = 1'b0;
    if (scan_valid) begin
      case (state)
        DEC_IDLE:  make_evt  = (scan_code != SC_BREAK) && (scan_code != SC_EXT);
        DEC_BREAK: break_evt = 1'b1;
        default: begin
          make_evt  = 1'b0;
          break_evt = 1'b0;
        end
      endcase
    end
  end

  assign code = scan_code;

endmodule

// File: rtl/ps2_note_mapper.sv
// PS/2 note mapper: last-pressed piano key plus octave shift -> tone-generator half-period.
// All three outputs are registered and change at most once per accepted byte.
module ps2_note_mapper
  import ps2_note_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input logic               clk,
  input logic               rst,
  ps2_note_mapper_if.slave  bus
);

  logic            make_evt;
  logic            break_evt;
  logic [7:0]      code;

  ps2_code_decoder u_decoder (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (bus.scan_code),
    .scan_valid (bus.scan_valid),
    .make_evt   (make_evt),
    .break_evt  (break_evt),
    .code       (code)
  );

  logic [HP_W-1:0] base_tab [16];

  for (genvar i = 0; i < 16; i++) begin : g_base
    assign base_tab[i] = HP_W'(note_base(longint'(CLK_HZ), i));
  end

  function automatic logic signed [2:0] oct_step(input logic signed [2:0] oct, input logic up);
    logic signed [2:0] r;
    if (up) r = (oct >= OCT_MAX) ? OCT_MAX : oct + 3'sd1;
    else    r = (oct <= OCT_MIN) ? OCT_MIN : oct - 3'sd1;
    return r;
  endfunction

  function automatic logic [HP_W-1:0] hp_calc(input logic [HP_W-1:0] base,
                                              input logic signed [2:0] oct);
    logic [HP_W-1:0] t;
    case (oct)
      3'sd1:   t = base >> 1;
      3'sd2:   t = base >> 2;
      -3'sd1:  t = base << 1;
      -3'sd2:  t = base << 2;
      default: t = base;
    endcase
    return t - HP_W'(1);
  endfunction

  logic [3:0]        key_q, key_n, idx;
  logic              note_q, note_n;
  logic signed [2:0] oct_q, oct_n;
  logic [HP_W-1:0]   hp_q, hp_n;
  logic              recompute;

  assign idx = note_of(code);

  // Last-pressed priority: a new make steals the note, only its own break releases it.
  always_comb begin
    key_n     = key_q;
    note_n    = note_q;
    oct_n     = oct_q;
    recompute = 1'b0;
    if (make_evt) begin
      if (code == SC_OCT_DN) begin
        oct_n = oct_step(oct_q, 1'b0);
      end else if (code == SC_OCT_UP) begin
        oct_n = oct_step(oct_q, 1'b1);
      end else if (idx != NOTE_NONE && idx != key_q) begin
        key_n     = idx;
        note_n    = 1'b1;
        recompute = 1'b1;
      end
    end else if (break_evt) begin
      if (idx != NOTE_NONE && idx == key_q) begin
        key_n  = NOTE_NONE;
        note_n = 1'b0;
      end
    end
    if (oct_n != oct_q && note_q) recompute = 1'b1;
    hp_n = recompute ? hp_calc(base_tab[key_n], oct_n) : hp_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q  <= NOTE_NONE;
      note_q <= 1'b0;
      oct_q  <= 3'sd0;
      hp_q   <= '0;
    end else begin
      key_q  <= key_n;
      note_q <= note_n;
      oct_q  <= oct_n;
      hp_q   <= hp_n;
    end
  end

  assign bus.half_period = hp_q;
  assign bus.note_on     = note_q;
  assign bus.octave      = oct_q;

endmodule

// File: tb/tb_ps2_note_mapper.sv
// Directed bench for ps2_note_mapper at 50 MHz with hand-computed half-period values.
module tb_ps2_note_mapper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  ps2_note_mapper_if bus ();

  ps2_note_mapper #(.CLK_HZ(50_000_000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b);
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.half_period !== 26'd0) begin
      fails++; $display("FAIL reset_hp: got %0d expected 0", bus.half_period);
    end
    tests++;
    if (bus.note_on !== 1'b0) begin
      fails++; $display("FAIL reset_note: got %0b expected 0", bus.note_on);
    end
    tests++;
    if (bus.octave !== 3'sd0) begin
      fails++; $display("FAIL reset_oct: got %0d expected 0", $signed(bus.octave));
    end
  endtask

  task automatic test_make_break();
    send(8'h1C);
    tests++;
    if (bus.half_period !== 26'd95555 || bus.note_on !== 1'b1) begin
      fails++; $display("FAIL make_c4: got hp=%0d on=%0b expected hp=95555 on=1", bus.half_period, bus.note_on);
    end
    send(8'hF0); send(8'h1C);
    tests++;
    if (bus.half_period !== 26'd95555 || bus.note_on !== 1'b0) begin
      fails++; $display("FAIL break_c4: got hp=%0d on=%0b expected hp=95555 on=0", bus.half_period, bus.note_on);
    end
  endtask

  task automatic test_octave();
    send(8'h33);
    tests++;
    if (bus.half_period !== 26'd56817 || bus.note_on !== 1'b1) begin
      fails++; $display("FAIL make_a4: got hp=%0d on=%0b expected hp=56817 on=1", bus.half_period, bus.note_on);
    end
    send(8'h22);
    tests++;
    if (bus.octave !== 3'sd1 || bus.half_period !== 26'd28408) begin
      fails++; $display("FAIL oct_up: got oct=%0d hp=%0d expected oct=1 hp=28408", $signed(bus.octave), bus.half_period);
    end
    send(8'h1A); send(8'h1A); send(8'h1A);
    tests++;
    if (bus.octave !== -3'sd2 || bus.half_period !== 26'd227271) begin
      fails++; $display("FAIL oct_down3: got oct=%0d hp=%0d expected oct=-2 hp=227271", $signed(bus.octave), bus.half_period);
    end
    send(8'h1A);
    tests++;
    if (bus.octave !== -3'sd2 || bus.half_period !== 26'd227271) begin
      fails++; $display("FAIL oct_sat_low: got oct=%0d hp=%0d expected oct=-2 hp=227271", $signed(bus.octave), bus.half_period);
    end
    send(8'hF0); send(8'h22);
    tests++;
    if (bus.octave !== -3'sd2) begin
      fails++; $display("FAIL oct_break_ignored: got oct=%0d expected -2", $signed(bus.octave));
    end
    repeat (5) send(8'h22);
    tests++;
    if (bus.octave !== 3'sd2 || bus.half_period !== 26'd14203) begin
      fails++; $display("FAIL oct_sat_high: got oct=%0d hp=%0d expected oct=2 hp=14203", $signed(bus.octave), bus.half_period);
    end
    send(8'h1A); send(8'h1A);
    tests++;
    if (bus.octave !== 3'sd0 || bus.half_period !== 26'd56817) begin
      fails++; $display("FAIL oct_back_zero: got oct=%0d hp=%0d expected oct=0 hp=56817", $signed(bus.octave), bus.half_period);
    end
    send(8'hF0); send(8'h33);
    send(8'h22);
    tests++;
    if (bus.octave !== 3'sd1 || bus.half_period !== 26'd56817 || bus.note_on !== 1'b0) begin
      fails++; $display("FAIL oct_note_off_hold: got oct=%0d hp=%0d on=%0b expected oct=1 hp=56817 on=0", $signed(bus.octave), bus.half_period, bus.note_on);
    end
    send(8'h1A);
  endtask

  task automatic test_priority();
    send(8'h1C); send(8'h33); send(8'hF0); send(8'h1C);
    tests++;
    if (bus.note_on !== 1'b1 || bus.half_period !== 26'd56817) begin
      fails++; $display("FAIL last_pressed: got hp=%0d on=%0b expected hp=56817 on=1", bus.half_period, bus.note_on);
    end
    send(8'hF0); send(8'h33);
    tests++;
    if (bus.note_on !== 1'b0) begin
      fails++; $display("FAIL release_current: got on=%0b expected 0", bus.note_on);
    end
  endtask

  task automatic test_extended();
    send(8'hE0); send(8'h1C);
    tests++;
    if (bus.note_on !== 1'b0 || bus.half_period !== 26'd56817 || bus.octave !== 3'sd0) begin
      fails++; $display("FAIL ext_make: got hp=%0d on=%0b oct=%0d expected hp=56817 on=0 oct=0", bus.half_period, bus.note_on, $signed(bus.octave));
    end
    send(8'hE0); send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h22);
    tests++;
    if (bus.note_on !== 1'b0 || bus.half_period !== 26'd56817 || bus.octave !== 3'sd0) begin
      fails++; $display("FAIL ext_break_oct: got hp=%0d on=%0b oct=%0d expected hp=56817 on=0 oct=0", bus.half_period, bus.note_on, $signed(bus.octave));
    end
    send(8'h1C);
    tests++;
    if (bus.note_on !== 1'b1 || bus.half_period !== 26'd95555) begin
      fails++; $display("FAIL after_ext: got hp=%0d on=%0b expected hp=95555 on=1", bus.half_period, bus.note_on);
    end
    send(8'hF0); send(8'h1C);
  endtask

  task automatic test_back_to_back();
    send_byte(8'h1C);
    tests++;
    if (bus.note_on !== 1'b0) begin
      fails++; $display("FAIL latency_before_edge: got on=%0b expected 0", bus.note_on);
    end
    send_byte(8'h1C);
    tests++;
    if (bus.note_on !== 1'b1 || bus.half_period !== 26'd95555) begin
      fails++; $display("FAIL b2b_first: got hp=%0d on=%0b expected hp=95555 on=1", bus.half_period, bus.note_on);
    end
    send_byte(8'h1C);
    tests++;
    if (bus.note_on !== 1'b1) begin
      fails++; $display("FAIL b2b_second: got on=%0b expected 1", bus.note_on);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    tests++;
    if (bus.note_on !== 1'b1 || bus.half_period !== 26'd95555) begin
      fails++; $display("FAIL b2b_third: got hp=%0d on=%0b expected hp=95555 on=1", bus.half_period, bus.note_on);
    end
    idle();
    tests++;
    if (bus.note_on !== 1'b0) begin
      fails++; $display("FAIL b2b_break: got on=%0b expected 0", bus.note_on);
    end
  endtask

  task automatic test_reset_mid();
    send(8'h1C); send(8'h22);
    tests++;
    if (bus.note_on !== 1'b1 || bus.half_period !== 26'd47777) begin
      fails++; $display("FAIL pre_reset: got hp=%0d on=%0b expected hp=47777 on=1", bus.half_period, bus.note_on);
    end
    send(8'hF0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.half_period !== 26'd0 || bus.note_on !== 1'b0 || bus.octave !== 3'sd0) begin
      fails++; $display("FAIL async_reset: got hp=%0d on=%0b oct=%0d expected all 0", bus.half_period, bus.note_on, $signed(bus.octave));
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'h1C);
    tests++;
    if (bus.note_on !== 1'b1 || bus.half_period !== 26'd95555) begin
      fails++; $display("FAIL prefix_discarded: got hp=%0d on=%0b expected hp=95555 on=1", bus.half_period, bus.note_on);
    end
  endtask

  initial begin
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    test_reset();
    test_make_break();
    test_octave();
    test_priority();
    test_extended();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
